// File: rtl/wb_trace_buffer_if.sv
// rtl/wb_trace_buffer_if.sv - WB retire-trace capture and consumer bus bundle
//
// Groups the WB debug inputs, the control inputs and the trace consumer
// handshake.
//   master: the environment. It drives enable, flush, debug_wb_* and
//           trace_ready, and observes the buffer outputs.
//   slave : the trace buffer. It drives trace_valid, trace_data, fifo_count,
//           almost_full and overflow_cnt.
interface wb_trace_buffer_if #(
    parameter int DEPTH = 8,
    parameter int OVF_W = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic               enable;
    logic               flush;
    logic [31:0]        debug_wb_pc;
    logic               debug_wb_rf_wen;
    logic [4:0]         debug_wb_rf_wnum;
    logic [31:0]        debug_wb_rf_wdata;
    logic               trace_valid;
    logic               trace_ready;
    logic [68:0]        trace_data;
    logic [CW-1:0]      fifo_count;
    logic               almost_full;
    logic [OVF_W-1:0]   overflow_cnt;

    modport master (
        output enable, flush, debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum,
               debug_wb_rf_wdata, trace_ready,
        input  trace_valid, trace_data, fifo_count, almost_full, overflow_cnt
    );

    modport slave (
        input  enable, flush, debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum,
               debug_wb_rf_wdata, trace_ready,
        output trace_valid, trace_data, fifo_count, almost_full, overflow_cnt
    );
endinterface

// File: rtl/wb_trace_buffer.sv
// rtl/wb_trace_buffer.sv - FIFO trace of retired register-file writes with drop counter
//
// The buffer captures every enabled WB register write to a non-zero
// destination as {wnum, pc, wdata}. It holds these entries in a DEPTH-entry
// FIFO, and a valid/ready consumer drains the FIFO. When the FIFO is full
// and no pop happens in the same cycle, the capture is dropped and counted
// in a saturating counter.
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-high
//   bus   : wb_trace_buffer_if.slave (capture inputs, flush, trace handshake,
//           occupancy, almost_full, overflow_cnt)
module wb_trace_buffer #(
    parameter int DEPTH = 8,
    parameter int OVF_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    wb_trace_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]    FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0]    AF_LVL   = (AW+1)'(DEPTH - 2);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
    localparam logic [OVF_W-1:0] OVF_ONE = OVF_W'(1);

    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             r_valid;
    logic [OVF_W-1:0] r_ovf;
    logic [68:0]      r_mem [DEPTH];

    logic             w_req;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [AW:0]      w_count_nxt;

    // Writes to r0 are architecturally discarded, so they are never traced.
    assign w_req  = bus.enable && bus.debug_wb_rf_wen && (bus.debug_wb_rf_wnum != 5'd0);
    assign w_full = (r_count == FULL_LVL);
    assign w_pop  = r_valid && bus.trace_ready;
    // At full, a pop in the same cycle frees the slot that the push refills.
    assign w_push = w_req && (!w_full || w_pop);
    assign w_drop = w_req && w_full && !w_pop;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_ovf   <= '0;
        end else if (bus.flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_ovf   <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            r_count <= w_count_nxt;
            // trace_valid gets its own register and mirrors the next occupancy.
            r_valid <= (w_count_nxt != '0);
            if (w_drop && (r_ovf != '1)) begin
                r_ovf <= r_ovf + OVF_ONE;
            end
        end
    end

    // The storage array has no reset. Its contents are don't-care whenever
    // the occupancy does not cover them.
    always_ff @(posedge clk) begin
        if (w_push && !bus.flush) begin
            r_mem[r_wptr] <= {bus.debug_wb_rf_wnum, bus.debug_wb_pc, bus.debug_wb_rf_wdata};
        end
    end

    assign bus.trace_valid  = r_valid;
    assign bus.trace_data   = r_mem[r_rptr];
    assign bus.fifo_count   = r_count;
    assign bus.almost_full  = (r_count >= AF_LVL);
    assign bus.overflow_cnt = r_ovf;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb/tb_wb_trace_buffer.sv - randomized and directed bench for wb_trace_buffer
module tb_wb_trace_buffer;
    localparam int DEPTH = 8;
    localparam int OVF_W = 4;
    localparam int OVF_MAX = (1 << OVF_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wb_trace_buffer_if #(.DEPTH(DEPTH), .OVF_W(OVF_W)) bus ();

    wb_trace_buffer #(.DEPTH(DEPTH), .OVF_W(OVF_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;
    logic [68:0] mq[$];
    int movf = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [68:0] act, input logic [68:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model: a queue of entries plus a saturating drop count.
    always @(posedge clk) begin
        if (!reset) begin : model
            int sz;
            bit req;
            bit pop;
            sz  = mq.size();
            req = bus.enable && bus.debug_wb_rf_wen && (bus.debug_wb_rf_wnum != 5'd0);
            pop = (sz > 0) && bus.trace_ready;
            if (bus.flush) begin
                mq.delete();
                movf = 0;
            end else begin
                if (pop) void'(mq.pop_front());
                if (req) begin
                    if (sz < DEPTH || pop)
                        mq.push_back({bus.debug_wb_rf_wnum, bus.debug_wb_pc, bus.debug_wb_rf_wdata});
                    else if (movf < OVF_MAX)
                        movf++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("valid", 69'(bus.trace_valid), 69'(mq.size() != 0));
            chk("count", 69'(bus.fifo_count), 69'(mq.size()));
            chk("almost_full", 69'(bus.almost_full), 69'(mq.size() >= DEPTH - 2));
            chk("overflow_cnt", 69'(bus.overflow_cnt), 69'(movf));
            if (mq.size() != 0) chk("data", bus.trace_data, mq[0]);
        end
    end

    task automatic cyc(input bit en, input bit wen, input logic [4:0] wn,
                       input logic [31:0] pc, input logic [31:0] wd,
                       input bit rdy, input bit fl);
        bus.enable            = en;
        bus.debug_wb_rf_wen   = wen;
        bus.debug_wb_rf_wnum  = wn;
        bus.debug_wb_pc       = pc;
        bus.debug_wb_rf_wdata = wd;
        bus.trace_ready       = rdy;
        bus.flush             = fl;
        @(negedge clk);
    endtask

    initial begin
        cyc(0, 0, 5'd0, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_valid", 69'(bus.trace_valid), 69'd0);
        chk("rst_count", 69'(bus.fifo_count), 69'd0);
        chk("rst_ovf", 69'(bus.overflow_cnt), 69'd0);
        chk("rst_af", 69'(bus.almost_full), 69'd0);

        // basic capture
        cyc(1, 1, 5'd3, 32'h1c000000, 32'h12345678, 0, 0);
        chk("basic_valid", 69'(bus.trace_valid), 69'd1);
        chk("basic_data", bus.trace_data, {5'd3, 32'h1c000000, 32'h12345678});
        chk("basic_count", 69'(bus.fifo_count), 69'd1);
        chk("model_head", mq[0], {5'd3, 32'h1c000000, 32'h12345678});
        cyc(0, 0, 5'd0, 32'h0, 32'h0, 1, 0);
        chk("basic_drain", 69'(bus.fifo_count), 69'd0);

        // r0 filter
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 5'd0, 32'h400 + 32'(i), 32'hdead0000 + 32'(i), 0, 0);
            chk("r0_count", 69'(bus.fifo_count), 69'd0);
            chk("r0_valid", 69'(bus.trace_valid), 69'd0);
        end

        // overflow
        for (int i = 0; i < 10; i++)
            cyc(1, 1, 5'(i + 1), 32'h1000 + 32'(i * 4), 32'ha000 + 32'(i), 0, 0);
        chk("ovf_count", 69'(bus.fifo_count), 69'd8);
        chk("ovf_cnt", 69'(bus.overflow_cnt), 69'd2);
        chk("ovf_af", 69'(bus.almost_full), 69'd1);
        for (int i = 0; i < 8; i++) begin
            chk("ovf_drain_data", bus.trace_data,
                {5'(i + 1), 32'h1000 + 32'(i * 4), 32'ha000 + 32'(i)});
            cyc(0, 0, 5'd0, 32'h0, 32'h0, 1, 0);
        end
        chk("ovf_empty", 69'(bus.fifo_count), 69'd0);

        // full with simultaneous push and pop
        for (int i = 0; i < 8; i++)
            cyc(1, 1, 5'd7, 32'h2000 + 32'(i), 32'hb000 + 32'(i), 0, 0);
        cyc(1, 1, 5'd9, 32'h2fff, 32'hbeef, 1, 0);
        chk("fullpp_count", 69'(bus.fifo_count), 69'd8);
        chk("fullpp_ovf", 69'(bus.overflow_cnt), 69'd2);
        for (int i = 0; i < 8; i++) begin
            if (i == 0) chk("fullpp_first", bus.trace_data, {5'd7, 32'h2001, 32'hb001});
            if (i == 7) chk("fullpp_last", bus.trace_data, {5'd9, 32'h2fff, 32'hbeef});
            cyc(0, 0, 5'd0, 32'h0, 32'h0, 1, 0);
        end

        // flush priority
        cyc(0, 0, 5'd0, 32'h0, 32'h0, 0, 1);
        chk("flush_ovf0", 69'(bus.overflow_cnt), 69'd0);
        for (int i = 0; i < 11; i++)
            cyc(1, 1, 5'd4, 32'h3000 + 32'(i), 32'hc000 + 32'(i), 0, 0);
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 5'd0, 32'h0, 32'h0, 1, 0);
        chk("pre_flush_count", 69'(bus.fifo_count), 69'd5);
        chk("pre_flush_ovf", 69'(bus.overflow_cnt), 69'd3);
        cyc(1, 1, 5'd4, 32'h3fff, 32'hcfff, 1, 1);
        chk("flush_count", 69'(bus.fifo_count), 69'd0);
        chk("flush_ovf", 69'(bus.overflow_cnt), 69'd0);
        chk("flush_valid", 69'(bus.trace_valid), 69'd0);

        // saturation of the drop counter
        for (int i = 0; i < 30; i++)
            cyc(1, 1, 5'd5, 32'h5000 + 32'(i), 32'hd000 + 32'(i), 0, 0);
        chk("sat_ovf", 69'(bus.overflow_cnt), 69'(OVF_MAX));
        cyc(0, 0, 5'd0, 32'h0, 32'h0, 0, 1);

        // asynchronous reset mid-operation
        for (int i = 0; i < 4; i++)
            cyc(1, 1, 5'd6, 32'h6000 + 32'(i), 32'he000 + 32'(i), 0, 0);
        chk("pre_rst_count", 69'(bus.fifo_count), 69'd4);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", 69'(bus.trace_valid), 69'd0);
        chk("arst_count", 69'(bus.fifo_count), 69'd0);
        mq.delete();
        movf = 0;
        @(negedge clk);
        reset = 1'b0;
        cyc(1, 1, 5'd8, 32'h7000, 32'hf000, 0, 0);
        chk("post_rst_head", bus.trace_data, {5'd8, 32'h7000, 32'hf000});
        cyc(1, 1, 5'd8, 32'h7004, 32'hf001, 0, 0);
        chk("post_rst_count", 69'(bus.fifo_count), 69'd2);

        // randomized traffic in phases with different drain rates
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 1000; i++) begin
                cyc($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                    5'($urandom_range(0, 31)), $urandom, $urandom,
                    (p == 0) ? ($urandom_range(0, 3) == 0) :
                    (p == 1) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 3) != 0),
                    $urandom_range(0, 99) == 0);
            end
        end
        cyc(0, 0, 5'd0, 32'h0, 32'h0, 1, 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
